color_centroid_tracker: RTL and testbench

Parametrised successor to the per-column colour-histogram centroid path. It consumes a raster-ordered RGB pixel stream and classifies each pixel against a 3-bit colour filter. It accumulates the match count and the X/Y coordinate sums, then computes the integer centroid (X and Y) with a bit-serial divider. It also owns the frame-source rotation, generalising the two-ROM alternation to NUM_SRC sources, and sits between the image sources and the motor/LED logic.

---
 rtl/color_centroid_tracker_if.sv | 38 +++
 rtl/color_centroid_tracker.sv | 234 +++++++++++++++++++++++
 tb/tb_color_centroid_tracker.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_centroid_tracker_if.sv
// Pixel-stream and result bus between the image sources, the centroid tracker
// and the motor/LED logic.
interface color_centroid_tracker_if #(
    parameter int unsigned IMG_W   = 80,
    parameter int unsigned IMG_H   = 60,
    parameter int unsigned PXL_W   = 12,
    parameter int unsigned NUM_SRC = 2
);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W * IMG_H + 1);
    localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Stream side
    logic [2:0]       rgbfilter;
    logic             frame_start;
    logic             pxl_valid;
    logic [PXL_W-1:0] pxl;

    // Result side
    logic             busy;
    logic [SW-1:0]    src_sel;
    logic [CW-1:0]    pix_count;
    logic [XW-1:0]    cent_x;
    logic [YW-1:0]    cent_y;
    logic             found;
    logic             result_valid;

    modport master (
        output rgbfilter, frame_start, pxl_valid, pxl,
        input  busy, src_sel, pix_count, cent_x, cent_y, found, result_valid
    );

    modport slave (
        input  rgbfilter, frame_start, pxl_valid, pxl,
        output busy, src_sel, pix_count, cent_x, cent_y, found, result_valid
    );
endinterface

// File: rtl/color_centroid_tracker.sv
// Colour-filtered centroid of a raster pixel stream: accumulates match count and
// coordinate sums per frame, divides bit-serially, and rotates the frame source.
module color_centroid_tracker #(
    parameter int unsigned IMG_W     = 80,
    parameter int unsigned IMG_H     = 60,
    parameter int unsigned PXL_W     = 12,
    parameter int unsigned COLOR_THR = 8,
    parameter int unsigned MIN_PIX   = 4,
    parameter int unsigned NUM_SRC   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    color_centroid_tracker_if.slave bus
);
    localparam int unsigned XW  = $clog2(IMG_W);
    localparam int unsigned YW  = $clog2(IMG_H);
    localparam int unsigned CW  = $clog2(IMG_W * IMG_H + 1);
    localparam int unsigned SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CHW = PXL_W / 3;
    localparam int unsigned SXW = $clog2(IMG_W * IMG_H * (IMG_W - 1) + 1);
    localparam int unsigned SYW = $clog2(IMG_W * IMG_H * (IMG_H - 1) + 1);
    localparam int unsigned QW  = (XW > YW) ? XW : YW;
    localparam int unsigned KW  = $clog2(QW + 1);
    localparam int unsigned RW  = (SXW > SYW) ? SXW : SYW;
    localparam int unsigned DVW = CW + QW;
    localparam int unsigned AW  = (RW > DVW) ? RW : DVW;

    localparam logic [CHW-1:0] THR = CHW'(COLOR_THR);

    typedef enum logic [2:0] {
        IDLE, ACCUM, CHECK, DIV_X, DIV_Y, DONE
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      filt_q, filt_d;
    logic [XW-1:0]   col_q, col_d;
    logic [YW-1:0]   row_q, row_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SXW-1:0]  sum_x_q, sum_x_d;
    logic [SYW-1:0]  sum_y_q, sum_y_d;
    logic [AW-1:0]   rem_q, rem_d;
    logic [AW-1:0]   dvs_q, dvs_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [KW-1:0]   step_q, step_d;
    logic [XW-1:0]   res_x_q, res_x_d;
    logic            busy_q, busy_d;
    logic [SW-1:0]   src_sel_q, src_sel_d;
    logic [CW-1:0]   pix_count_q, pix_count_d;
    logic [XW-1:0]   cent_x_q, cent_x_d;
    logic [YW-1:0]   cent_y_q, cent_y_d;
    logic            found_q, found_d;
    logic            result_valid_q, result_valid_d;

    logic [CHW-1:0]  ch_r_c, ch_g_c, ch_b_c;
    logic [2:0]      hi_c;
    logic            match_c;
    logic            q_bit_c;
    logic [QW-1:0]   q_next_c;
    logic            done_c;

    // Per-channel threshold classification against the frame's latched filter
    assign ch_r_c  = bus.pxl[PXL_W-1 -: CHW];
    assign ch_g_c  = bus.pxl[2*CHW-1 -: CHW];
    assign ch_b_c  = bus.pxl[CHW-1:0];
    assign hi_c    = {ch_r_c >= THR, ch_g_c >= THR, ch_b_c >= THR};
    assign match_c = (filt_q != 3'b000) && (hi_c == filt_q);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            filt_q         <= '0;
            col_q          <= '0;
            row_q          <= '0;
            count_q        <= '0;
            sum_x_q        <= '0;
            sum_y_q        <= '0;
            rem_q          <= '0;
            dvs_q          <= '0;
            quo_q          <= '0;
            step_q         <= '0;
            res_x_q        <= '0;
            busy_q         <= 1'b0;
            src_sel_q      <= '0;
            pix_count_q    <= '0;
            cent_x_q       <= '0;
            cent_y_q       <= '0;
            found_q        <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            filt_q         <= filt_d;
            col_q          <= col_d;
            row_q          <= row_d;
            count_q        <= count_d;
            sum_x_q        <= sum_x_d;
            sum_y_q        <= sum_y_d;
            rem_q          <= rem_d;
            dvs_q          <= dvs_d;
            quo_q          <= quo_d;
            step_q         <= step_d;
            res_x_q        <= res_x_d;
            busy_q         <= busy_d;
            src_sel_q      <= src_sel_d;
            pix_count_q    <= pix_count_d;
            cent_x_q       <= cent_x_d;
            cent_y_q       <= cent_y_d;
            found_q        <= found_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state: accumulate, gate on MIN_PIX, restoring divide X then Y, publish
    always_comb begin
        state_d        = state_q;
        filt_d         = filt_q;
        col_d          = col_q;
        row_d          = row_q;
        count_d        = count_q;
        sum_x_d        = sum_x_q;
        sum_y_d        = sum_y_q;
        rem_d          = rem_q;
        dvs_d          = dvs_q;
        quo_d          = quo_q;
        step_d         = step_q;
        res_x_d        = res_x_q;
        src_sel_d      = src_sel_q;
        pix_count_d    = pix_count_q;
        cent_x_d       = cent_x_q;
        cent_y_d       = cent_y_q;
        found_d        = found_q;
        result_valid_d = 1'b0;
        done_c         = 1'b0;
        q_bit_c        = (rem_q >= dvs_q);
        q_next_c       = (quo_q << 1) | QW'(q_bit_c);

        unique case (state_q)
            IDLE, ACCUM: begin
                if (bus.frame_start) begin
                    filt_d  = bus.rgbfilter;
                    col_d   = '0;
                    row_d   = '0;
                    count_d = '0;
                    sum_x_d = '0;
                    sum_y_d = '0;
                    state_d = ACCUM;
                end else if (state_q == ACCUM && bus.pxl_valid) begin
                    if (match_c) begin
                        count_d = count_q + CW'(1);
                        sum_x_d = sum_x_q + SXW'(col_q);
                        sum_y_d = sum_y_q + SYW'(row_q);
                    end
                    if (col_q == XW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + YW'(1);
                        if (row_q == YW'(IMG_H - 1)) begin
                            state_d = CHECK;
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
            end
            CHECK: begin
                if (count_q < CW'(MIN_PIX) || count_q == '0) begin
                    cent_x_d = '0;
                    cent_y_d = '0;
                    found_d  = 1'b0;
                    done_c   = 1'b1;
                end else begin
                    rem_d   = AW'(sum_x_q);
                    dvs_d   = AW'(count_q) << (XW - 1);
                    quo_d   = '0;
                    step_d  = '0;
                    state_d = DIV_X;
                end
            end
            DIV_X: begin
                if (q_bit_c) begin
                    rem_d = rem_q - dvs_q;
                end
                dvs_d  = dvs_q >> 1;
                quo_d  = q_next_c;
                step_d = step_q + KW'(1);
                if (step_q == KW'(XW - 1)) begin
                    res_x_d = XW'(q_next_c);
                    rem_d   = AW'(sum_y_q);
                    dvs_d   = AW'(count_q) << (YW - 1);
                    quo_d   = '0;
                    step_d  = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                if (q_bit_c) begin
                    rem_d = rem_q - dvs_q;
                end
                dvs_d  = dvs_q >> 1;
                quo_d  = q_next_c;
                step_d = step_q + KW'(1);
                if (step_q == KW'(YW - 1)) begin
                    cent_x_d = res_x_q;
                    cent_y_d = YW'(q_next_c);
                    found_d  = 1'b1;
                    done_c   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering DONE publishes the result and rotates the source
        if (done_c) begin
            state_d        = DONE;
            pix_count_d    = count_q;
            result_valid_d = 1'b1;
            src_sel_d      = (src_sel_q == SW'(NUM_SRC - 1)) ? '0 : src_sel_q + SW'(1);
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.busy         = busy_q;
    assign bus.src_sel      = src_sel_q;
    assign bus.pix_count    = pix_count_q;
    assign bus.cent_x       = cent_x_q;
    assign bus.cent_y       = cent_y_q;
    assign bus.found        = found_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_color_centroid_tracker.sv
// Bench for color_centroid_tracker: two instances (defaults, and MIN_PIX=1 with
// NUM_SRC=3) share one pixel stream; per-frame expectations are tabulated.
module tb_color_centroid_tracker;
    localparam int unsigned IMG_W = 80;
    localparam int unsigned IMG_H = 60;
    localparam int unsigned PXL_W = 12;
    localparam int          NPIX  = IMG_W * IMG_H;

    localparam int P_BLOCK  = 0;
    localparam int P_BLACK  = 1;
    localparam int P_WHITE  = 2;
    localparam int P_THREE  = 3;
    localparam int P_CORNER = 4;
    localparam int P_THR    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       rgbfilter;
    logic             frame_start;
    logic             pxl_valid;
    logic [PXL_W-1:0] pxl;

    always #5 clk = ~clk;

    color_centroid_tracker_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PXL_W(PXL_W), .NUM_SRC(2)) bus_a ();
    color_centroid_tracker_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PXL_W(PXL_W), .NUM_SRC(3)) bus_b ();

    assign bus_a.rgbfilter   = rgbfilter;
    assign bus_a.frame_start = frame_start;
    assign bus_a.pxl_valid   = pxl_valid;
    assign bus_a.pxl         = pxl;
    assign bus_b.rgbfilter   = rgbfilter;
    assign bus_b.frame_start = frame_start;
    assign bus_b.pxl_valid   = pxl_valid;
    assign bus_b.pxl         = pxl;

    color_centroid_tracker #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PXL_W(PXL_W),
        .COLOR_THR(8), .MIN_PIX(4), .NUM_SRC(2)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    color_centroid_tracker #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PXL_W(PXL_W),
        .COLOR_THR(8), .MIN_PIX(1), .NUM_SRC(3)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        logic [2:0] filt;
        int pat;
        int stall;      // 0 none, 1 alternate cycles, 2 alternate plus random stalls
        int fs_in_div;  // pulse frame_start while dividing
        int cnt;
        int ax, ay, af, a_lat, a_src;
        int bx, by, bf, b_lat, b_src;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_cnt_a = 0, rv_cnt_b = 0;
    int rv_cyc_a = 0, rv_cyc_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result_valid cycle and when it happened
    always @(negedge clk) begin
        if (bus_a.result_valid === 1'b1) begin
            rv_cnt_a <= rv_cnt_a + 1;
            rv_cyc_a <= cyc;
        end
        if (bus_b.result_valid === 1'b1) begin
            rv_cnt_b <= rv_cnt_b + 1;
            rv_cyc_b <= cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [PXL_W-1:0] pix(input int pat, input int c, input int r);
        case (pat)
            P_BLOCK:  return (c >= 10 && c <= 19 && r >= 20 && r <= 29) ? 12'hF00 : 12'h000;
            P_BLACK:  return 12'h000;
            P_WHITE:  return 12'hFFF;
            P_THREE:  return ((c == 3 && r == 1) || (c == 4 && r == 1) || (c == 8 && r == 4))
                             ? 12'h800 : 12'h7FF;
            P_CORNER: return (c == 79 && r == 59) ? 12'hF00 : 12'h000;
            P_THR: begin
                if (r < 2 && c < 40) return 12'h880;
                else if (r == 2)     return 12'h7F0;
                else if (r == 3)     return 12'h888;
                else                 return 12'h000;
            end
            default:  return 12'h000;
        endcase
    endfunction

    // Called on a falling edge; returns on the next falling edge
    task automatic start_frame(input logic [2:0] f);
        rgbfilter   = f;
        frame_start = 1'b1;
        pxl_valid   = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        rgbfilter   = ~f;
    endtask

    // Returns on the falling edge right after the edge that took the last pixel
    task automatic send_pixels(input int pat, input int stall, input int npix);
        int  n = 0, c = 0, r = 0;
        bit  tog = 1'b0;
        bit  v;
        while (n < npix) begin
            v = 1'b1;
            if (stall != 0) begin
                tog = ~tog;
                v   = tog;
            end
            if (stall == 2 && $urandom_range(0, 4) == 0) v = 1'b0;
            pxl_valid = v;
            pxl       = v ? pix(pat, c, r) : 12'hF00;
            @(negedge clk);
            if (v) begin
                n++;
                c++;
                if (c == int'(IMG_W)) begin
                    c = 0;
                    r++;
                end
            end
        end
        pxl_valid = 1'b0;
        pxl       = '0;
    endtask

    task automatic finish_frame(input vec_t v, input string tag);
        int c0, ca, cb;
        send_pixels(v.pat, v.stall, NPIX);
        c0 = cyc;
        ca = rv_cnt_a;
        cb = rv_cnt_b;
        check({tag, " busy_a after last pixel"}, int'(bus_a.busy), 1);
        check({tag, " busy_b after last pixel"}, int'(bus_b.busy), 1);
        if (v.fs_in_div != 0) begin
            repeat (2) @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        repeat (24) @(negedge clk);
        check({tag, " result_valid pulses a"}, rv_cnt_a - ca, 1);
        check({tag, " result_valid pulses b"}, rv_cnt_b - cb, 1);
        check({tag, " latency a"}, rv_cyc_a - c0, v.a_lat);
        check({tag, " latency b"}, rv_cyc_b - c0, v.b_lat);
        check({tag, " pix_count a"}, int'(bus_a.pix_count), v.cnt);
        check({tag, " pix_count b"}, int'(bus_b.pix_count), v.cnt);
        check({tag, " cent_x a"}, int'(bus_a.cent_x), v.ax);
        check({tag, " cent_y a"}, int'(bus_a.cent_y), v.ay);
        check({tag, " found a"}, int'(bus_a.found), v.af);
        check({tag, " cent_x b"}, int'(bus_b.cent_x), v.bx);
        check({tag, " cent_y b"}, int'(bus_b.cent_y), v.by);
        check({tag, " found b"}, int'(bus_b.found), v.bf);
        check({tag, " src_sel a"}, int'(bus_a.src_sel), v.a_src);
        check({tag, " src_sel b"}, int'(bus_b.src_sel), v.b_src);
        check({tag, " busy a idle"}, int'(bus_a.busy), 0);
        check({tag, " busy b idle"}, int'(bus_b.busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy a"}, int'(bus_a.busy), 0);
        check({tag, " src_sel a"}, int'(bus_a.src_sel), 0);
        check({tag, " pix_count a"}, int'(bus_a.pix_count), 0);
        check({tag, " cent_x a"}, int'(bus_a.cent_x), 0);
        check({tag, " cent_y a"}, int'(bus_a.cent_y), 0);
        check({tag, " found a"}, int'(bus_a.found), 0);
        check({tag, " result_valid a"}, int'(bus_a.result_valid), 0);
        check({tag, " busy b"}, int'(bus_b.busy), 0);
        check({tag, " src_sel b"}, int'(bus_b.src_sel), 0);
        check({tag, " pix_count b"}, int'(bus_b.pix_count), 0);
        check({tag, " cent_x b"}, int'(bus_b.cent_x), 0);
        check({tag, " cent_y b"}, int'(bus_b.cent_y), 0);
        check({tag, " found b"}, int'(bus_b.found), 0);
        check({tag, " result_valid b"}, int'(bus_b.result_valid), 0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v_restart;
        int   ca, cb;

        //            filt    pat       stl fs  cnt  ax  ay af lat src  bx  by bf lat src
        vecs[0] = '{3'b100, P_BLOCK,  0,  1, 100, 14, 24, 1, 14, 1, 14, 24, 1, 14, 1};
        vecs[1] = '{3'b010, P_BLACK,  0,  0,   0,  0,  0, 0,  1, 0,  0,  0, 0,  1, 2};
        vecs[2] = '{3'b000, P_WHITE,  0,  0,   0,  0,  0, 0,  1, 1,  0,  0, 0,  1, 0};
        vecs[3] = '{3'b100, P_THREE,  0,  0,   3,  0,  0, 0,  1, 0,  5,  2, 1, 14, 1};
        vecs[4] = '{3'b100, P_CORNER, 0,  0,   1,  0,  0, 0,  1, 1, 79, 59, 1, 14, 2};
        vecs[5] = '{3'b110, P_THR,    1,  0,  80, 19,  0, 1, 14, 0, 19,  0, 1, 14, 0};
        vecs[6] = '{3'b100, P_BLOCK,  2,  0, 100, 14, 24, 1, 14, 1, 14, 24, 1, 14, 1};

        rst         = 1'b1;
        rgbfilter   = '0;
        frame_start = 1'b0;
        pxl_valid   = 1'b0;
        pxl         = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Pixels offered while idle must not start or disturb anything
        pxl_valid = 1'b1;
        pxl       = 12'hF00;
        repeat (4) @(negedge clk);
        pxl_valid = 1'b0;
        check("idle pxl_valid busy a", int'(bus_a.busy), 0);

        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i].filt);
            finish_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort after 1000 matching pixels, then restart and complete
        ca = rv_cnt_a;
        cb = rv_cnt_b;
        start_frame(3'b111);
        send_pixels(P_WHITE, 0, 1000);
        start_frame(3'b100);
        check("abort busy a", int'(bus_a.busy), 1);
        check("abort result_valid a", rv_cnt_a - ca, 0);
        check("abort result_valid b", rv_cnt_b - cb, 0);
        check("abort src_sel a", int'(bus_a.src_sel), 1);
        check("abort src_sel b", int'(bus_b.src_sel), 1);
        v_restart           = vecs[0];
        v_restart.fs_in_div = 0;
        v_restart.a_src     = 0;
        v_restart.b_src     = 2;
        finish_frame(v_restart, "restart");

        // Reset during DIV_Y aborts silently
        start_frame(3'b100);
        send_pixels(P_BLOCK, 0, NPIX);
        ca = rv_cnt_a;
        cb = rv_cnt_b;
        repeat (10) @(negedge clk);
        check("pre-reset busy a", int'(bus_a.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        check("mid reset result_valid a", rv_cnt_a - ca, 0);
        check("mid reset result_valid b", rv_cnt_b - cb, 0);
        check("mid reset busy a", int'(bus_a.busy), 0);

        start_frame(vecs[0].filt);
        finish_frame(vecs[0], "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
